am_offset: RTL and testbench

//  - Removes the DC/carrier offset from a signed AM sample stream (envelope or baseband path of the SDR).
//  - Estimates the offset as rounded block means of 2^LOG2_N valid samples, smoothed by a first-order IIR.
//  - Outputs the input minus the current estimate, saturated, plus the estimate itself.

---
 rtl/am_offset_pkg.sv | 37 +++
 rtl/am_block_mean.sv | 82 ++++++++
 rtl/am_offset.sv | 127 ++++++++++++
 tb/tb_am_offset.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/am_offset_pkg.sv
// Shared defaults, lock-state encoding and the saturating subtract helper
// for the AM offset remover.
package am_offset_pkg;

  localparam int unsigned DATA_W_DEF      = 16;
  localparam int unsigned LOG2_N_DEF      = 10;
  localparam int unsigned ALPHA_SHIFT_DEF = 3;

  // Estimate tracking: no block mean seen yet, or smoothing an existing estimate.
  typedef enum logic {
    LOCK_IDLE  = 1'b0,
    LOCK_TRACK = 1'b1
  } lock_state_e;

  // a - b computed one bit wider than the operands, then clamped to the signed
  // range of a w-bit word. Operands are sign-extended w-bit values (w <= 31).
  function automatic logic signed [31:0] sat_sub(
    input logic signed [31:0] a,
    input logic signed [31:0] b,
    input int unsigned        w
  );
    logic signed [32:0] diff;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    diff = 33'(a) - 33'(b);
    hi   = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo   = -hi - 33'sd1;
    if (diff > hi) begin
      return 32'(hi);
    end else if (diff < lo) begin
      return 32'(lo);
    end else begin
      return 32'(diff);
    end
  endfunction

endpackage

// File: rtl/am_block_mean.sv
// Accumulates 2^LOG2_N valid samples and emits their rounded (half-up) mean
// as a registered value with a one-cycle mean_valid pulse.
module am_block_mean
  import am_offset_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned LOG2_N = LOG2_N_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] data,
  input  logic                     valid,
  output logic signed [DATA_W-1:0] mean,
  output logic                     mean_valid
);

  localparam int unsigned AW = DATA_W + LOG2_N;

  localparam logic signed [AW:0] HALF     = (AW + 1)'(1) <<< (LOG2_N - 1);
  localparam logic signed [AW:0] MEAN_MAX = (AW + 1)'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [AW:0] MEAN_MIN = -MEAN_MAX - (AW + 1)'(1);

  logic signed [AW-1:0]     acc_q,  acc_d;
  logic        [LOG2_N-1:0] cnt_q,  cnt_d;
  logic signed [DATA_W-1:0] mean_q, mean_d;
  logic                     mean_valid_q, mean_valid_d;

  logic signed [AW:0] sum_rnd;
  logic signed [AW:0] shifted;
  logic signed [AW:0] clipped;

  // Accumulate, close the block on the N-th valid sample and round its mean.
  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    mean_d       = mean_q;
    mean_valid_d = 1'b0;

    // Closing sum includes the current sample; one extra bit keeps the
    // rounding constant from ever wrapping.
    sum_rnd = (AW + 1)'(acc_q) + (AW + 1)'(data) + HALF;
    shifted = sum_rnd >>> LOG2_N;
    if (shifted > MEAN_MAX) begin
      clipped = MEAN_MAX;
    end else if (shifted < MEAN_MIN) begin
      clipped = MEAN_MIN;
    end else begin
      clipped = shifted;
    end

    if (valid) begin
      if (cnt_q == '1) begin
        acc_d        = '0;
        cnt_d        = '0;
        mean_d       = DATA_W'(clipped);
        mean_valid_d = 1'b1;
      end else begin
        acc_d = acc_q + AW'(data);
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Block accumulator, sample counter and registered mean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      mean_q       <= '0;
      mean_valid_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      mean_q       <= mean_d;
      mean_valid_q <= mean_valid_d;
    end
  end

  assign mean       = mean_q;
  assign mean_valid = mean_valid_q;

endmodule

// File: rtl/am_offset.sv
// AM offset remover: block-mean offset estimate smoothed by a first-order IIR,
// subtracted with saturation from the sample stream.
module am_offset
  import am_offset_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned LOG2_N      = LOG2_N_DEF,
  parameter int unsigned ALPHA_SHIFT = ALPHA_SHIFT_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic signed [DATA_W-1:0] iS_data,
  input  logic                     i_valid,
  output logic signed [DATA_W-1:0] oS_data,
  output logic                     o_valid,
  output logic signed [DATA_W-1:0] oS_offset,
  output logic                     o_offset_valid,
  output logic                     o_locked
);

  localparam int unsigned EW = DATA_W + ALPHA_SHIFT;

  // Half an LSB of the integer part; zero when there are no fraction bits.
  localparam logic signed [EW:0] OFF_HALF = ((EW + 1)'(1) <<< ALPHA_SHIFT) >>> 1;

  logic signed [DATA_W-1:0] mean;
  logic                     mean_valid;

  lock_state_e              state_q, state_d;
  logic signed [EW-1:0]     est_q, est_d;
  logic                     est_upd_q, est_upd_d;
  logic signed [DATA_W-1:0] offset_q, offset_d;
  logic                     offset_valid_q, offset_valid_d;
  logic signed [DATA_W-1:0] data_q, data_d;
  logic                     valid_q, valid_d;

  logic signed [EW:0] mean_sh;
  logic signed [EW:0] diff;
  logic signed [EW:0] step;
  logic signed [EW:0] off_rnd;

  am_block_mean #(
    .DATA_W (DATA_W),
    .LOG2_N (LOG2_N)
  ) u_block_mean (
    .clk        (i_clk),
    .rst        (i_reset),
    .data       (iS_data),
    .valid      (i_valid),
    .mean       (mean),
    .mean_valid (mean_valid)
  );

  // Lock state and IIR estimate: first mean preloads, later means are smoothed.
  always_comb begin
    state_d   = state_q;
    est_d     = est_q;
    est_upd_d = 1'b0;

    // Difference carries a guard bit so the full-scale swing cannot wrap.
    mean_sh = (EW + 1)'(mean) <<< ALPHA_SHIFT;
    diff    = mean_sh - (EW + 1)'(est_q);
    step    = diff >>> ALPHA_SHIFT;

    if (mean_valid) begin
      est_upd_d = 1'b1;
      case (state_q)
        LOCK_IDLE: begin
          est_d   = EW'(mean_sh);
          state_d = LOCK_TRACK;
        end
        LOCK_TRACK: begin
          est_d = est_q + EW'(step);
        end
        default: begin
          state_d = LOCK_IDLE;
        end
      endcase
    end
  end

  // Rounded offset published one cycle after the estimate moves; corrected
  // samples always use the offset register as it stood before this edge.
  always_comb begin
    offset_d       = offset_q;
    offset_valid_d = est_upd_q;
    data_d         = data_q;
    valid_d        = i_valid;

    off_rnd = (EW + 1)'(est_q) + OFF_HALF;
    if (est_upd_q) begin
      offset_d = DATA_W'(off_rnd >>> ALPHA_SHIFT);
    end

    if (i_valid) begin
      data_d = DATA_W'(sat_sub(32'(iS_data), 32'(offset_q), DATA_W));
    end
  end

  // Lock state, estimate and output registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q        <= LOCK_IDLE;
      est_q          <= '0;
      est_upd_q      <= 1'b0;
      offset_q       <= '0;
      offset_valid_q <= 1'b0;
      data_q         <= '0;
      valid_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      est_q          <= est_d;
      est_upd_q      <= est_upd_d;
      offset_q       <= offset_d;
      offset_valid_q <= offset_valid_d;
      data_q         <= data_d;
      valid_q        <= valid_d;
    end
  end

  assign oS_data        = data_q;
  assign o_valid        = valid_q;
  assign oS_offset      = offset_q;
  assign o_offset_valid = offset_valid_q;
  assign o_locked       = (state_q == LOCK_TRACK);

endmodule

// File: tb/tb_am_offset.sv
// Directed bench for am_offset: reset, passthrough, lock timing, IIR steps,
// rounding, saturation, valid gaps and mid-block reset.
module tb_am_offset;

  logic               clk;
  logic               i_reset;
  logic signed [15:0] iS_data;
  logic               i_valid;
  logic signed [15:0] oS_data;
  logic               o_valid;
  logic signed [15:0] oS_offset;
  logic               o_offset_valid;
  logic               o_locked;

  int unsigned vectors;
  int unsigned miscompares;

  am_offset #(
    .DATA_W      (16),
    .LOG2_N      (10),
    .ALPHA_SHIFT (3)
  ) dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .iS_data        (iS_data),
    .i_valid        (i_valid),
    .oS_data        (oS_data),
    .o_valid        (o_valid),
    .oS_offset      (oS_offset),
    .o_offset_valid (o_offset_valid),
    .o_locked       (o_locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; outputs are sampled 1ns after the edge.
  task automatic samp(input int d);
    iS_data = 16'(d);
    i_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    iS_data = '0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    idle(2);
    i_reset = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    i_reset     = 1'b1;
    i_valid     = 1'b0;
    iS_data     = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", oS_data, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_offset", oS_offset, 0);
    chk("rst_offv", o_offset_valid, 0);
    chk("rst_locked", o_locked, 0);
    i_reset = 1'b0;
    idle(3);
    chk("idle_data", oS_data, 0);
    chk("idle_valid", o_valid, 0);
    chk("idle_locked", o_locked, 0);

    // Pre-lock passthrough, including the 16-bit ramp wrap
    samp(123);
    chk("pass_123", oS_data, 123);
    chk("pass_valid", o_valid, 1);
    samp(32767);
    chk("pass_max", oS_data, 32767);
    samp(-32768);
    chk("pass_min", oS_data, -32768);
    idle(1);
    chk("gap_valid", o_valid, 0);
    chk("gap_hold", oS_data, -32768);

    // Constant 1000 block: lock, then offset two edges after the last sample
    do_reset();
    for (int i = 0; i < 1024; i++) begin
      samp(1000);
      if (i == 0) chk("c1000_pre", oS_data, 1000);
    end
    chk("c1000_e0_lock", o_locked, 0);
    chk("c1000_e0_offv", o_offset_valid, 0);
    idle(1);
    chk("c1000_e1_lock", o_locked, 1);
    chk("c1000_e1_offv", o_offset_valid, 0);
    chk("c1000_e1_off", oS_offset, 0);
    idle(1);
    chk("c1000_e2_offv", o_offset_valid, 1);
    chk("c1000_e2_off", oS_offset, 1000);
    idle(1);
    chk("c1000_offv_pulse", o_offset_valid, 0);
    samp(1000);
    chk("c1000_corr", oS_data, 0);
    samp(-32768);
    chk("sat_low", oS_data, -32768);
    samp(500);
    chk("corr_500", oS_data, -500);

    // Step 1000 -> 2000: IIR converges 1125, 1234, 1330
    do_reset();
    for (int i = 0; i < 1024; i++) samp(1000);
    idle(2);
    chk("step_base", oS_offset, 1000);
    for (int i = 0; i < 1024; i++) begin
      samp(2000);
      if (i == 0) chk("step_b2_first", oS_data, 1000);
    end
    idle(2);
    chk("step_1125", oS_offset, 1125);
    chk("step_1125_offv", o_offset_valid, 1);
    for (int i = 0; i < 1024; i++) begin
      samp(2000);
      if (i == 0) chk("step_b3_first", oS_data, 875);
    end
    // Samples continue through the update: the update edge uses the old offset
    samp(2000);
    chk("coin_e1", oS_data, 875);
    samp(2000);
    chk("coin_e2", oS_data, 875);
    chk("coin_e2_off", oS_offset, 1234);
    chk("coin_e2_offv", o_offset_valid, 1);
    samp(2000);
    chk("coin_e3", oS_data, 766);
    for (int i = 0; i < 1021; i++) samp(2000);
    idle(2);
    chk("step_1330", oS_offset, 1330);

    // Ramp 0..1023 with valid toggling: block closes on valid samples only
    do_reset();
    for (int k = 0; k < 1024; k++) begin
      samp(k);
      if (k == 5) begin
        chk("ramp_v1", o_valid, 1);
        chk("ramp_d5", oS_data, 5);
      end
      idle(1);
      if (k == 5) begin
        chk("ramp_v0", o_valid, 0);
        chk("ramp_hold", oS_data, 5);
      end
      if (k == 1022) chk("ramp_unlocked", o_locked, 0);
    end
    chk("ramp_locked", o_locked, 1);
    idle(1);
    chk("ramp_offv", o_offset_valid, 1);
    chk("ramp_512", oS_offset, 512);

    // Negative offset, rounding of -999.5 and high-side saturation
    do_reset();
    for (int i = 0; i < 1024; i++) samp(-1000);
    idle(2);
    chk("neg_off", oS_offset, -1000);
    samp(32767);
    chk("sat_high", oS_data, 32767);
    samp(-32768);
    chk("neg_corr_min", oS_data, -31768);

    // Reset at sample 500 discards the partial block
    do_reset();
    for (int i = 0; i < 500; i++) samp(5000);
    do_reset();
    chk("mid_rst_lock", o_locked, 0);
    chk("mid_rst_off", oS_offset, 0);
    for (int i = 0; i < 1023; i++) samp(300);
    idle(2);
    chk("mid_1023_unlocked", o_locked, 0);
    samp(300);
    idle(2);
    chk("mid_locked", o_locked, 1);
    chk("mid_off_300", oS_offset, 300);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
